// File: rtl/flag_commit_sched_pkg.sv
// Shared types for the flag commit scheduler: entry state, flag word and unit priority.
// Index order of the unit constants is the arbitration order (lowest index wins).
package flag_commit_sched_pkg;

    typedef enum logic [1:0] {
        ENT_FREE = 2'd0,
        ENT_PEND = 2'd1,
        ENT_DONE = 2'd2
    } entState_t;

    typedef logic [4:0] flag_t;

    localparam int NUM_UNITS  = 4;
    localparam int UNIT_SHIFT = 0;
    localparam int UNIT_ADDER = 1;
    localparam int UNIT_MUL   = 2;
    localparam int UNIT_LOGIC = 3;

endpackage

// File: rtl/flag_commit_entry.sv
// One in-flight slot of the flag commit queue: lifecycle state plus stored flags.
// Free outranks allocate outranks complete; the top guarantees no conflicting strobes.
module flag_commit_entry
    import flag_commit_sched_pkg::*;
(
    input  logic      iCLOCK,
    input  logic      inRESET,
    input  logic      iCLEAR,
    input  logic      iALLOC,
    input  logic      iCOMPLETE,
    input  logic      iFREE,
    input  flag_t     iFLAG,
    output entState_t oSTATE,
    output flag_t     oFLAG
);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oSTATE <= ENT_FREE;
            oFLAG  <= '0;
        end else if (iCLEAR || iFREE) begin
            oSTATE <= ENT_FREE;
        end else if (iALLOC) begin
            oSTATE <= ENT_PEND;
        end else if (iCOMPLETE) begin
            oSTATE <= ENT_DONE;
            oFLAG  <= iFLAG;
        end
    end

endmodule

// File: rtl/flag_commit_sched.sv
// In-order flag commit scheduler: tags flag-writing instructions at issue, collects
// out-of-order unit completions, commits flags in allocation order. Option: FLAG_COMMIT_BYPASS_EN.
module flag_commit_sched
    import flag_commit_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
)(
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic             iRESET_SYNC,
    input  logic             iFLUSH,
    input  logic             iCTRL_HOLD,
    input  logic             iALLOC_VALID,
    output logic             oALLOC_READY,
    output logic [TAG_W-1:0] oALLOC_TAG,
    input  logic             iSHIFT_VALID,
    input  logic [TAG_W-1:0] iSHIFT_TAG,
    input  logic [4:0]       iSHIFT_FLAG,
    input  logic             iADDER_VALID,
    input  logic [TAG_W-1:0] iADDER_TAG,
    input  logic [4:0]       iADDER_FLAG,
    input  logic             iMUL_VALID,
    input  logic [TAG_W-1:0] iMUL_TAG,
    input  logic [4:0]       iMUL_FLAG,
    input  logic             iLOGIC_VALID,
    input  logic [TAG_W-1:0] iLOGIC_TAG,
    input  logic [4:0]       iLOGIC_FLAG,
    output logic             oFLAG_WRITE,
    output logic [4:0]       oFLAG,
    output logic [TAG_W-1:0] oFLAG_TAG,
    output logic             oBUSY,
    output logic             oPROTO_ERR
);

    logic             clear;
    logic [TAG_W-1:0] headPtr, tailPtr;
    logic [TAG_W:0]   count;
    logic             alloc, commit, commitNormal, commitBypass, protoErrSet;
    flag_t            commitFlag;

    entState_t        entState [DEPTH];
    flag_t            entFlag  [DEPTH];
    flag_t            compFlag [DEPTH];
    logic [DEPTH-1:0] entHit, entAlloc, entComplete, entFree;

    logic [NUM_UNITS-1:0] unitValid;
    logic [TAG_W-1:0]     unitTag  [NUM_UNITS];
    flag_t                unitFlag [NUM_UNITS];

    assign unitValid[UNIT_SHIFT] = iSHIFT_VALID;
    assign unitValid[UNIT_ADDER] = iADDER_VALID;
    assign unitValid[UNIT_MUL]   = iMUL_VALID;
    assign unitValid[UNIT_LOGIC] = iLOGIC_VALID;
    assign unitTag[UNIT_SHIFT]   = iSHIFT_TAG;
    assign unitTag[UNIT_ADDER]   = iADDER_TAG;
    assign unitTag[UNIT_MUL]     = iMUL_TAG;
    assign unitTag[UNIT_LOGIC]   = iLOGIC_TAG;
    assign unitFlag[UNIT_SHIFT]  = iSHIFT_FLAG;
    assign unitFlag[UNIT_ADDER]  = iADDER_FLAG;
    assign unitFlag[UNIT_MUL]    = iMUL_FLAG;
    assign unitFlag[UNIT_LOGIC]  = iLOGIC_FLAG;

    assign clear        = iFLUSH | iRESET_SYNC;
    assign oALLOC_READY = (count != (TAG_W+1)'(DEPTH)) && !clear;
    assign oALLOC_TAG   = tailPtr;
    assign oBUSY        = (count != '0);
    assign alloc        = iALLOC_VALID && oALLOC_READY;

    // Walk units from lowest to highest priority so the highest-priority hit lands last.
    always_comb begin
        entHit      = '0;
        protoErrSet = 1'b0;
        for (int e = 0; e < DEPTH; e++) compFlag[e] = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int u = NUM_UNITS - 1; u >= 0; u--) begin
                if (unitValid[u] && unitTag[u] == TAG_W'(e)) begin
                    entHit[e]   = 1'b1;
                    compFlag[e] = unitFlag[u];
                end
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unitValid[u] && entState[unitTag[u]] != ENT_PEND) protoErrSet = 1'b1;
        end
        if (clear) protoErrSet = 1'b0;
    end

    assign commitNormal = (entState[headPtr] == ENT_DONE) && !iCTRL_HOLD && !clear;
`ifdef FLAG_COMMIT_BYPASS_EN
    assign commitBypass = (entState[headPtr] == ENT_PEND) && entHit[headPtr] && !iCTRL_HOLD && !clear;
`else
    assign commitBypass = 1'b0;
`endif
    assign commit     = commitNormal | commitBypass;
    assign commitFlag = commitNormal ? entFlag[headPtr] : compFlag[headPtr];

    for (genvar e = 0; e < DEPTH; e++) begin : gEnt
        assign entAlloc[e]    = alloc && (tailPtr == TAG_W'(e));
        assign entFree[e]     = commit && (headPtr == TAG_W'(e));
        assign entComplete[e] = entHit[e] && (entState[e] == ENT_PEND) && !clear;

        flag_commit_entry uEntry (
            .iCLOCK    (iCLOCK),
            .inRESET   (inRESET),
            .iCLEAR    (clear),
            .iALLOC    (entAlloc[e]),
            .iCOMPLETE (entComplete[e]),
            .iFREE     (entFree[e]),
            .iFLAG     (compFlag[e]),
            .oSTATE    (entState[e]),
            .oFLAG     (entFlag[e])
        );
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            oFLAG_WRITE <= 1'b0;
            oFLAG       <= '0;
            oFLAG_TAG   <= '0;
            oPROTO_ERR  <= 1'b0;
        end else if (clear) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            oFLAG_WRITE <= 1'b0;
            if (iRESET_SYNC) begin
                oFLAG      <= '0;
                oPROTO_ERR <= 1'b0;
            end
        end else begin
            if (alloc)  tailPtr <= tailPtr + TAG_W'(1);
            if (commit) headPtr <= headPtr + TAG_W'(1);
            count       <= count + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
            oFLAG_WRITE <= commit;
            if (commit) begin
                oFLAG     <= commitFlag;
                oFLAG_TAG <= headPtr;
            end
            if (protoErrSet) oPROTO_ERR <= 1'b1;
        end
    end

endmodule

// File: doc/flag_commit_sched.md
FLAG_COMMIT_SCHED -- requirements
Module: flag_commit_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight flag-writing instructions (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 2, tag width, equal to log2(DEPTH).
REQ-003 iCLOCK  input  1  sole clock, rising edge.
REQ-004 inRESET  input  1  asynchronous, active-low reset.
REQ-005 iRESET_SYNC  input  1  synchronous clear.
REQ-006 iFLUSH  input  1  pipeline flush / PFLAGR restore; discards all entries.
REQ-007 iCTRL_HOLD  input  1  stalls commit.
REQ-008 iALLOC_VALID  input  1  issue stage requests a tag for a flag-writing instruction.
REQ-009 oALLOC_READY  output  1  allocation accepted this cycle when high.
REQ-010 oALLOC_TAG  output  TAG_W  tag granted, valid with iALLOC_VALID && oALLOC_READY.
REQ-011 iSHIFT_VALID/iADDER_VALID/iMUL_VALID/iLOGIC_VALID  input  1 each  unit completion strobe.
REQ-012 iSHIFT_TAG/iADDER_TAG/iMUL_TAG/iLOGIC_TAG  input  TAG_W each  completing instruction tag.
REQ-013 iSHIFT_FLAG/iADDER_FLAG/iMUL_FLAG/iLOGIC_FLAG  input  5 each  result flags.
REQ-014 oFLAG_WRITE  output  1  registered one-cycle commit strobe to the flag register.
REQ-015 oFLAG  output  5  committed flag value, valid with oFLAG_WRITE.
REQ-016 oFLAG_TAG  output  TAG_W  tag of committed entry.
REQ-017 oBUSY  output  1  at least one entry outstanding.
REQ-018 oPROTO_ERR  output  1  sticky: completion to a non-pending tag.

Function
REQ-019 SHALL hold a circular queue of DEPTH entries, each FREE, PEND or DONE, with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-020 oALLOC_READY SHALL equal (count != DEPTH) && !iFLUSH && !iRESET_SYNC; accepted allocation marks tail PEND, outputs tail as oALLOC_TAG, advances tail.
REQ-021 A completion to a PEND entry SHALL store its flags and mark it DONE; to a FREE or DONE entry it SHALL be ignored and set oPROTO_ERR.
REQ-022 Same-cycle completions with different tags SHALL all be accepted; same tag from several units SHALL resolve SHIFT > ADDER > MUL > LOGIC, losers ignored without error.
REQ-023 When head is DONE and iCTRL_HOLD is low, SHALL on the next edge pulse oFLAG_WRITE with that entry's flags/tag, free it and advance head; at most one commit per cycle.
REQ-024 Commits SHALL occur strictly in allocation order; a DONE entry behind a PEND head waits.
REQ-025 Base latency: completion in cycle N to head -> oFLAG_WRITE high in cycle N+2.
REQ-026 Allocation and commit in one cycle SHALL leave count unchanged; full queue with a same-cycle commit SHALL still deassert oALLOC_READY.
REQ-027 iFLUSH SHALL free all entries, zero pointers/count, suppress that cycle's allocation, completions and commit; oPROTO_ERR unchanged.
REQ-028 oBUSY SHALL equal count != 0.

Reset
REQ-029 inRESET low SHALL asynchronously set all entries FREE, pointers/count 0, oFLAG_WRITE 0, oFLAG 0, oFLAG_TAG 0, oPROTO_ERR 0.
REQ-030 iRESET_SYNC high SHALL act as iFLUSH and additionally clear oPROTO_ERR and oFLAG; inRESET dominates, iRESET_SYNC dominates iFLUSH.

Configuration
REQ-031 Macro FLAG_COMMIT_BYPASS_EN defined: a completion to the current head with iCTRL_HOLD low SHALL commit directly, oFLAG_WRITE in cycle N+1, winning unit per REQ-022.
REQ-032 Macro undefined: no bypass; all commits pass through DONE state, latency per REQ-025.

Structure
REQ-033 Shared package SHALL hold the entry-state enum (FREE/PEND/DONE), the 5-bit flag type and the unit-priority order constant.
REQ-034 One sub-module flag_commit_entry (single entry state plus flag storage) SHALL be instantiated DEPTH times; pointers and arbitration stay in the top.

Verification
REQ-035 Allocate tags 0,1; ADDER completes tag0 flags 5'h03 cycle N -> oFLAG_WRITE, oFLAG=5'h03, tag 0 at N+2 (N+1 with bypass).
REQ-036 Allocate 0,1; MUL completes tag1 5'h10, then LOGIC tag0 5'h01 -> commits 5'h01 then 5'h10 on consecutive cycles.
REQ-037 Allocate 4 -> oALLOC_READY=0; commit one, allocate -> tag 0 granted (wrap), count stays 4.
REQ-038 SHIFT and ADDER both complete tag0 with 5'h04/5'h08 -> commit 5'h04.
REQ-039 Head DONE with iCTRL_HOLD high 3 cycles -> no commit; release -> commit next cycle.
REQ-040 Three entries pending, iFLUSH -> oBUSY=0 next cycle, no commit; late completion to old tag -> oPROTO_ERR=1, cleared only by iRESET_SYNC or inRESET.
